accel_uart_tx: RTL and testbench

ACCEL_UART_TX -- requirements
Module: accel_uart_tx

---
 rtl/accel_uart_pkg.sv | 20 ++
 rtl/accel_uart_fifo.sv | 62 ++++++
 rtl/accel_uart_tx.sv | 166 ++++++++++++++++
 tb/tb_accel_uart_tx.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_uart_pkg.sv
// rtl/accel_uart_pkg.sv - shared types and sizing for the accelerator UART transmitter
package accel_uart_pkg;

    localparam int SOC_UART1_LOG2_FIFOSZ = 4;
    localparam int DEFAULT_LOG2_FIFOSZ   = SOC_UART1_LOG2_FIFOSZ;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // A programmed bit period of zero behaves as one clock per bit.
    function automatic logic [15:0] eff_scaler(input logic [15:0] scaler);
        return (scaler == 16'd0) ? 16'd1 : scaler;
    endfunction

endpackage

// File: rtl/accel_uart_fifo.sv
// rtl/accel_uart_fifo.sv - byte FIFO feeding the UART transmitter
module accel_uart_fifo #(
    parameter int dbits      = 8,
    parameter int log2_depth = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  we,
    input  logic [dbits-1:0]      wdata,
    input  logic                  re,
    output logic [dbits-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [log2_depth:0]   count
);

    localparam int depth = 1 << log2_depth;
    localparam logic [log2_depth:0] full_lvl = {1'b1, {log2_depth{1'b0}}};

    logic [dbits-1:0]      mem [depth];
    logic [log2_depth-1:0] wr_ptr;
    logic [log2_depth-1:0] rd_ptr;
    logic [log2_depth:0]   count_q;
    logic                  do_re;
    logic                  do_we;

    assign full  = (count_q == full_lvl);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem[rd_ptr];

    // A pop on the same edge frees the slot, so a write is accepted even when full.
    assign do_re = re && !empty;
    assign do_we = we && (!full || do_re);

    always_ff @(posedge clk) begin
        if (do_we) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_we) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_re) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_we, do_re})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/accel_uart_tx.sv
// rtl/accel_uart_tx.sv - FIFO-buffered UART transmitter with optional parity and two stop bits
module accel_uart_tx
    import accel_uart_pkg::*;
#(
    parameter int log2_fifosz = DEFAULT_LOG2_FIFOSZ
) (
    input  logic                   i_clk,
    input  logic                   i_nrst,
    input  logic [15:0]            i_scaler,
    input  logic                   i_parity_en,
    input  logic                   i_parity_odd,
    input  logic                   i_stop2,
    input  logic                   i_we,
    input  logic [7:0]             i_wdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [log2_fifosz:0]   o_count,
    output logic                   o_busy,
    output logic                   o_txd
);

    tx_state_t   state_q;
    tx_state_t   state_d;
    logic [15:0] baud_q;
    logic [15:0] period_q;
    logic [2:0]  bit_idx_q;
    logic [2:0]  bit_idx_d;
    logic        stop_cnt_q;
    logic        stop_cnt_d;
    logic [7:0]  shreg_q;
    logic        par_q;
    logic        par_en_q;
    logic        stop2_q;
    logic        txd_q;
    logic        txd_d;
    logic        pop;
    logic        shift;
    logic        tick;
    logic [7:0]  fifo_rdata;

    accel_uart_fifo #(
        .dbits      (8),
        .log2_depth (log2_fifosz)
    ) u_fifo (
        .clk   (i_clk),
        .nrst  (i_nrst),
        .we    (i_we),
        .wdata (i_wdata),
        .re    (pop),
        .rdata (fifo_rdata),
        .full  (o_full),
        .empty (o_empty),
        .count (o_count)
    );

    assign tick   = (baud_q == period_q - 16'd1);
    assign o_busy = (state_q != ST_IDLE);
    assign o_txd  = txd_q;

    always_comb begin
        state_d    = state_q;
        txd_d      = txd_q;
        pop        = 1'b0;
        shift      = 1'b0;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (!o_empty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                    txd_d   = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    txd_d     = shreg_q[0];
                    shift     = 1'b1;
                    bit_idx_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
                        stop_cnt_d = 1'b0;
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d = ST_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        txd_d     = shreg_q[0];
                        shift     = 1'b1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d    = ST_STOP;
                    txd_d      = 1'b1;
                    stop_cnt_d = 1'b0;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else if (!o_empty) begin
                        // Back-to-back frame: next start bit follows the stop bit directly.
                        pop     = 1'b1;
                        state_d = ST_START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q    <= ST_IDLE;
            txd_q      <= 1'b1;
            baud_q     <= 16'd0;
            period_q   <= 16'd1;
            bit_idx_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            shreg_q    <= 8'd0;
            par_q      <= 1'b0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            txd_q      <= txd_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            if (pop || tick || state_q == ST_IDLE) begin
                baud_q <= 16'd0;
            end else begin
                baud_q <= baud_q + 16'd1;
            end
            // Line settings are frozen per frame at the moment a byte is popped.
            if (pop) begin
                shreg_q  <= fifo_rdata;
                par_q    <= (^fifo_rdata) ^ i_parity_odd;
                par_en_q <= i_parity_en;
                stop2_q  <= i_stop2;
                period_q <= eff_scaler(i_scaler);
            end else if (shift) begin
                shreg_q <= {1'b0, shreg_q[7:1]};
            end
        end
    end

endmodule

// File: tb/tb_accel_uart_tx.sv
// tb/tb_accel_uart_tx.sv - self-checking bench for accel_uart_tx
module tb_accel_uart_tx;

    logic        i_clk = 1'b0;
    logic        i_nrst;
    logic [15:0] i_scaler;
    logic        i_parity_en;
    logic        i_parity_odd;
    logic        i_stop2;
    logic        i_we;
    logic [7:0]  i_wdata;
    logic        o_full;
    logic        o_empty;
    logic [4:0]  o_count;
    logic        o_busy;
    logic        o_txd;

    accel_uart_tx #(.log2_fifosz(4)) dut (
        .i_clk        (i_clk),
        .i_nrst       (i_nrst),
        .i_scaler     (i_scaler),
        .i_parity_en  (i_parity_en),
        .i_parity_odd (i_parity_odd),
        .i_stop2      (i_stop2),
        .i_we         (i_we),
        .i_wdata      (i_wdata),
        .o_full       (o_full),
        .o_empty      (o_empty),
        .o_count      (o_count),
        .o_busy       (o_busy),
        .o_txd        (o_txd)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } sb_t;

    typedef struct {
        logic [15:0] scaler;
        logic        par_en;
        logic        odd;
        logic        stop2;
        logic [7:0]  data;
        logic        exp_par;
        int          exp_cycles;
    } vec_t;

    sb_t  sbq[$];
    vec_t vecs[6];
    int   total = 0;
    int   bad   = 0;
    logic mon_en;
    int   cfg_period;
    logic cfg_par_en;
    logic cfg_stop2;
    int   n;
    int   viol;
    logic [19:0] cap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_cfg(input logic [15:0] sc, input logic pe, input logic od, input logic s2);
        i_scaler     = sc;
        i_parity_en  = pe;
        i_parity_odd = od;
        i_stop2      = s2;
        cfg_period   = (sc == 16'd0) ? 1 : int'(sc);
        cfg_par_en   = pe;
        cfg_stop2    = s2;
    endtask

    task automatic drain(input int bound);
        int k;
        k = 0;
        while ((sbq.size() != 0 || o_busy) && k < bound) begin
            k++;
            @(negedge i_clk);
        end
        chk("drain_in_time", k < bound, 1'b1);
        chk("drain_sb_empty", sbq.size(), 0);
    endtask

    // Serial line monitor: decodes frames at bit centres and scores them.
    always begin : mon
        logic [7:0] d;
        logic       p;
        logic       sb0;
        logic       s1;
        logic       s2;
        int         per;
        sb_t        e;
        @(negedge i_clk);
        if (mon_en && i_nrst && !o_txd) begin
            per = cfg_period;
            p   = 1'b0;
            repeat (per / 2) @(negedge i_clk);
            sb0 = o_txd;
            for (int k = 0; k < 8; k++) begin
                repeat (per) @(negedge i_clk);
                d[k] = o_txd;
            end
            if (cfg_par_en) begin
                repeat (per) @(negedge i_clk);
                p = o_txd;
            end
            repeat (per) @(negedge i_clk);
            s1 = o_txd;
            s2 = 1'b1;
            if (cfg_stop2) begin
                repeat (per) @(negedge i_clk);
                s2 = o_txd;
            end
            chk("frame_start_bit", sb0, 1'b0);
            chk("frame_expected", sbq.size() != 0, 1'b1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("frame_data", d, e.data);
                if (cfg_par_en) chk("frame_parity", p, e.par);
                chk("frame_stop", {s1, s2}, 2'b11);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'd4, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 40};
        vecs[1] = '{16'd0, 1'b0, 1'b0, 1'b0, 8'hA3, 1'b0, 10};
        vecs[2] = '{16'd3, 1'b1, 1'b0, 1'b0, 8'hA3, 1'b0, 33};
        vecs[3] = '{16'd2, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 24};
        vecs[4] = '{16'd1, 1'b1, 1'b0, 1'b1, 8'h7F, 1'b1, 12};
        vecs[5] = '{16'd5, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 55};

        i_nrst  = 1'b0;
        i_we    = 1'b0;
        i_wdata = 8'h00;
        mon_en  = 1'b0;
        set_cfg(16'd4, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge i_clk);
        chk("rst_txd", o_txd, 1'b1);
        chk("rst_empty", o_empty, 1'b1);
        chk("rst_full", o_full, 1'b0);
        chk("rst_count", o_count, 5'd0);
        chk("rst_busy", o_busy, 1'b0);
        i_nrst = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge i_clk);

        for (int v = 0; v < 6; v++) begin
            set_cfg(vecs[v].scaler, vecs[v].par_en, vecs[v].odd, vecs[v].stop2);
            @(negedge i_clk);
            i_we    = 1'b1;
            i_wdata = vecs[v].data;
            sbq.push_back('{data: vecs[v].data, par: vecs[v].exp_par});
            @(negedge i_clk);
            i_we = 1'b0;
            chk("txd_idle_before_start", o_txd, 1'b1);
            @(negedge i_clk);
            n = 0;
            while (o_busy && n < 5000) begin
                n++;
                @(negedge i_clk);
            end
            chk("frame_cycles", n, vecs[v].exp_cycles);
            chk("vec_sb_drained", sbq.size(), 0);
            chk("vec_txd_idle", o_txd, 1'b1);
        end

        // Two frames at one clock per bit must abut with no idle gap.
        set_cfg(16'd0, 1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        i_we    = 1'b1;
        i_wdata = 8'hA3;
        sbq.push_back('{data: 8'hA3, par: 1'b0});
        @(negedge i_clk);
        i_wdata = 8'h0F;
        sbq.push_back('{data: 8'h0F, par: 1'b0});
        @(negedge i_clk);
        i_we = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cap[19-k] = o_txd;
            @(negedge i_clk);
        end
        chk("b2b_waveform", cap, 20'b0110001011_0111100001);
        chk("b2b_busy_end", o_busy, 1'b0);
        drain(100);

        // Fill while the first frame is stalled on a very long bit period.
        mon_en = 1'b0;
        set_cfg(16'hFFFF, 1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        for (int k = 0; k < 18; k++) begin
            i_we    = 1'b1;
            i_wdata = 8'(k);
            @(negedge i_clk);
        end
        i_we = 1'b0;
        chk("fill_count", o_count, 5'd16);
        chk("fill_full", o_full, 1'b1);
        chk("fill_empty", o_empty, 1'b0);
        chk("fill_busy", o_busy, 1'b1);
        i_nrst = 1'b0;
        #1;
        chk("fill_rst_count", o_count, 5'd0);
        chk("fill_rst_full", o_full, 1'b0);
        chk("fill_rst_empty", o_empty, 1'b1);
        chk("fill_rst_txd", o_txd, 1'b1);
        chk("fill_rst_busy", o_busy, 1'b0);
        @(negedge i_clk);
        i_nrst = 1'b1;

        // Full FIFO: a write landing on the pop edge is kept, others are dropped.
        mon_en = 1'b1;
        set_cfg(16'd40, 1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        for (int k = 0; k < 17; k++) begin
            i_we    = 1'b1;
            i_wdata = 8'h10 + 8'(k);
            sbq.push_back('{data: 8'h10 + 8'(k), par: 1'b0});
            @(negedge i_clk);
        end
        i_wdata = 8'hEE;
        @(negedge i_clk);
        chk("drop_count", o_count, 5'd16);
        i_wdata = 8'h5A;
        sbq.push_back('{data: 8'h5A, par: 1'b0});
        viol = 0;
        for (int k = 0; k < 420; k++) begin
            @(negedge i_clk);
            if (o_count != 5'd16 || !o_full) viol++;
        end
        i_we = 1'b0;
        chk("full_simul_count_held", viol, 0);
        drain(10000);

        // Reset in the middle of data bit 3 with five bytes still queued.
        mon_en = 1'b0;
        set_cfg(16'd4, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge i_clk);
            i_we    = 1'b1;
            i_wdata = (k == 0) ? 8'hF7 : 8'(k);
        end
        @(negedge i_clk);
        i_we = 1'b0;
        repeat (13) @(negedge i_clk);
        chk("mid_bit3_txd", o_txd, 1'b0);
        chk("mid_count", o_count, 5'd5);
        i_nrst = 1'b0;
        #1;
        chk("mid_rst_txd", o_txd, 1'b1);
        chk("mid_rst_count", o_count, 5'd0);
        chk("mid_rst_busy", o_busy, 1'b0);
        repeat (2) @(negedge i_clk);
        i_nrst = 1'b1;
        viol = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge i_clk);
            if (o_txd !== 1'b1 || o_busy || !o_empty) viol++;
        end
        chk("post_rst_quiet", viol, 0);

        mon_en = 1'b1;
        @(negedge i_clk);
        i_we    = 1'b1;
        i_wdata = 8'h3C;
        sbq.push_back('{data: 8'h3C, par: 1'b0});
        @(negedge i_clk);
        i_we = 1'b0;
        drain(1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
